// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage in front of a registered-output program ROM.
// Owns the PC, drives rom_addr, captures the ROM word one cycle later and queues
// {pc, instruction} pairs for decode behind a valid/ready handshake. A redirect
// flushes the queue and the in-flight fetch and restarts fetching at redirect_pc.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   fetch_en          1 = issue new fetches, 0 = hold PC and drain
//   rom_addr          ROM address (the PC register)
//   rom_instr         ROM data for the address presented the previous cycle
//   redirect_valid    branch/jump taken; flush and load redirect_pc
//   redirect_pc       target PC
//   out_valid/ready   decode handshake
//   out_instr/out_pc  queue head
//   perf_fetched/perf_flushes  saturating counters, only with FETCH_PERF_EN
//
// Optional feature macro: FETCH_PERF_EN
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  output logic [15:0] rom_addr,
  input  logic [31:0] rom_instr,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [15:0] out_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [15:0] perf_flushes
`endif
);

  localparam int unsigned PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QDEPTH);

  typedef enum logic [1:0] {IDLE, RUN, FULL, FLUSH} state_t;

  state_t             state_q, state_d;
  logic [15:0]        pc_q;
  logic               inflight_v;
  logic [15:0]        inflight_pc;
  logic [15:0]        q_pc    [QDEPTH];
  logic [31:0]        q_instr [QDEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   occ, occ_d;
  logic [CNT_W-1:0]   count, count_d;
  logic               issue, push, pop;

  assign rom_addr  = pc_q;
  assign out_valid = (occ != '0);
  assign out_pc    = q_pc[rd_ptr];
  assign out_instr = q_instr[rd_ptr];

  // Credit, handshake and next-state decode.
  always_comb begin
    count   = occ + CNT_W'(inflight_v);
    push    = inflight_v;
    pop     = out_valid & out_ready;
    // Credit uses occupancy before this cycle's pop, so a push can never hit a full queue.
    issue   = fetch_en & ~redirect_valid & (count < DEPTH_C);
    occ_d   = occ;
    state_d = RUN;
    if (redirect_valid) begin
      occ_d = '0;
    end else if (push && !pop) begin
      occ_d = occ + CNT_W'(1);
    end else if (!push && pop) begin
      occ_d = occ - CNT_W'(1);
    end
    count_d = occ_d + CNT_W'(issue);
    if (redirect_valid) begin
      state_d = FLUSH;
    end else if (count_d == DEPTH_C) begin
      state_d = FULL;
    end else if (count_d == '0 && !fetch_en) begin
      state_d = IDLE;
    end
  end

  // PC, in-flight slot, queue storage and FSM state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      inflight_v  <= 1'b0;
      inflight_pc <= 16'h0000;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      occ         <= '0;
      for (int i = 0; i < int'(QDEPTH); i++) begin
        q_pc[i]    <= 16'h0000;
        q_instr[i] <= 32'h0000_0000;
      end
    end else begin
      state_q <= state_d;
      occ     <= occ_d;
      if (redirect_valid) begin
        // Everything in flight is dropped; a same-cycle pop already completed.
        pc_q       <= redirect_pc;
        inflight_v <= 1'b0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
      end else begin
        inflight_v <= issue;
        if (issue) begin
          inflight_pc <= pc_q;
          pc_q        <= pc_q + 16'd1;
        end
        if (push) begin
          q_pc[wr_ptr]    <= inflight_pc;
          q_instr[wr_ptr] <= rom_instr;
          wr_ptr          <= wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
      end
    end
  end

  // State consistency: FLUSH leaves nothing in flight, FULL means all credits used.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == FLUSH) assert (occ == '0 && !inflight_v);
      if (state_q == FULL)  assert (count == DEPTH_C);
    end
  end

`ifdef FETCH_PERF_EN
  // Saturating performance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched <= 32'h0000_0000;
      perf_flushes <= 16'h0000;
    end else begin
      if (pop && perf_fetched != 32'hFFFF_FFFF) perf_fetched <= perf_fetched + 32'd1;
      if (redirect_valid && perf_flushes != 16'hFFFF) perf_flushes <= perf_flushes + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit with a registered ROM model returning {16'hA5A5, addr}.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        fetch_en;
  logic [15:0] rom_addr;
  logic [31:0] rom_instr;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [15:0] out_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [15:0] perf_flushes;
`endif

  int n_total = 0;
  int n_pass  = 0;

  fetch_unit #(.RESET_PC(16'h0000), .QDEPTH(2)) dut (
    .clk(clk),
    .rst(rst),
    .fetch_en(fetch_en),
    .rom_addr(rom_addr),
    .rom_instr(rom_instr),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_instr(out_instr),
    .out_pc(out_pc)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_flushes(perf_flushes)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-output ROM.
  always @(posedge clk) rom_instr <= {16'hA5A5, rom_addr};

  typedef struct {
    int          stall;      // cycles of out_ready=0 before accepting this entry
    logic [15:0] hold_addr;  // rom_addr expected at the end of the stall
    logic [15:0] pc;         // expected head pc
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a valid head, check it, and let the handshake complete.
  task automatic expect_hs(input logic [15:0] pc, input int max_wait);
    int w;
    w = 0;
    @(negedge clk);
    while (!out_valid && w < max_wait) begin
      next_cycle();
      @(negedge clk);
      w++;
    end
    chk("hs_valid", 32'(out_valid), 32'd1);
    chk("hs_pc", 32'(out_pc), 32'(pc));
    chk("hs_instr", out_instr, {16'hA5A5, pc});
    next_cycle();
  endtask

  // Release reset and check the first two cycles of fetch startup.
  task automatic release_reset();
    rst = 1'b0; fetch_en = 1'b1; out_ready = 1'b1; redirect_valid = 1'b0;
    @(negedge clk);
    chk("rel_c0_addr", 32'(rom_addr), 32'h0000);
    chk("rel_c0_valid", 32'(out_valid), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("rel_c1_addr", 32'(rom_addr), 32'h0001);
    chk("rel_c1_valid", 32'(out_valid), 32'd0);
    next_cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end

  initial begin
    tbl[0] = '{0, 16'h0000, 16'h0000};
    tbl[1] = '{0, 16'h0000, 16'h0001};
    tbl[2] = '{0, 16'h0000, 16'h0002};
    tbl[3] = '{6, 16'h0005, 16'h0003};
    tbl[4] = '{0, 16'h0000, 16'h0004};
    tbl[5] = '{0, 16'h0000, 16'h0005};
    tbl[6] = '{0, 16'h0000, 16'h0006};

    rst = 1'b1; fetch_en = 1'b0; out_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 16'h0000;

    // Reset state.
    @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_addr", 32'(rom_addr), 32'h0000);
    chk("rst_pc", 32'(out_pc), 32'h0000);
    chk("rst_instr", out_instr, 32'h0);

    // Startup stream and backpressure, table driven.
    next_cycle();
    release_reset();
    for (int i = 0; i < 7; i++) begin
      if (tbl[i].stall > 0) begin
        out_ready = 1'b0;
        for (int k = 0; k < tbl[i].stall; k++) begin
          @(negedge clk);
          if (out_valid) chk("bp_head_pc", 32'(out_pc), 32'(tbl[i].pc));
          next_cycle();
        end
        @(negedge clk);
        chk("bp_pc_held", 32'(rom_addr), 32'(tbl[i].hold_addr));
        chk("bp_instr_held", out_instr, {16'hA5A5, tbl[i].pc});
        next_cycle();
        out_ready = 1'b1;
      end
      expect_hs(tbl[i].pc, (i == 0) ? 0 : 6);
    end

    // Redirect from a full queue.
    out_ready = 1'b0;
    repeat (6) next_cycle();
    @(negedge clk);
    chk("full_valid", 32'(out_valid), 32'd1);
    next_cycle();
    redirect_valid = 1'b1; redirect_pc = 16'h0100;
    next_cycle();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("rd1_valid", 32'(out_valid), 32'd0);
    chk("rd1_addr", 32'(rom_addr), 32'h0100);
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("rd1_head", 32'(out_pc), 32'h0100);
    // One entry queued and one in flight: back-to-back redirects, last wins.
    redirect_valid = 1'b1; redirect_pc = 16'h0300;
    next_cycle();
    redirect_pc = 16'h0040;
    next_cycle();
    redirect_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("rd2_valid", 32'(out_valid), 32'd0);
    chk("rd2_addr", 32'(rom_addr), 32'h0040);
    next_cycle();
    @(negedge clk);
    chk("rd2_valid_c2", 32'(out_valid), 32'd0);
    next_cycle();
    expect_hs(16'h0040, 0);
    expect_hs(16'h0041, 4);
    expect_hs(16'h0042, 4);

    // PC wrap.
    redirect_valid = 1'b1; redirect_pc = 16'hFFFE;
    next_cycle();
    redirect_valid = 1'b0;
    expect_hs(16'hFFFE, 2);
    expect_hs(16'hFFFF, 4);
    expect_hs(16'h0000, 4);
    expect_hs(16'h0001, 4);

    // Asynchronous reset between edges.
    #3;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_addr", 32'(rom_addr), 32'h0000);
    chk("arst_pc", 32'(out_pc), 32'h0000);
    next_cycle();
    release_reset();
    expect_hs(16'h0000, 0);
    expect_hs(16'h0001, 4);
    expect_hs(16'h0002, 4);

    // fetch_en drop with one word in flight.
    rst = 1'b1;
    next_cycle();
    rst = 1'b0; fetch_en = 1'b1; out_ready = 1'b1;
    next_cycle();
    fetch_en = 1'b0;
    @(negedge clk);
    chk("fe0_addr", 32'(rom_addr), 32'h0001);
    next_cycle();
    expect_hs(16'h0000, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("fe0_idle_valid", 32'(out_valid), 32'd0);
      chk("fe0_pc_hold", 32'(rom_addr), 32'h0001);
      next_cycle();
    end
    fetch_en = 1'b1;
    expect_hs(16'h0001, 4);
    expect_hs(16'h0002, 4);
    out_ready = 1'b0;
`ifdef FETCH_PERF_EN
    @(negedge clk);
    chk("perf_fetched", perf_fetched, 32'd3);
    chk("perf_flushes0", 32'(perf_flushes), 32'd0);
    next_cycle();
`endif
    redirect_valid = 1'b1; redirect_pc = 16'h0010;
    next_cycle();
    next_cycle();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("fin_addr", 32'(rom_addr), 32'h0010);
    chk("fin_valid", 32'(out_valid), 32'd0);
`ifdef FETCH_PERF_EN
    chk("perf_flushes", 32'(perf_flushes), 32'd2);
    chk("perf_fetched_hold", perf_fetched, 32'd3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
